// File: rtl/mem_pkg.sv
// Shared memory-channel definitions: the arbiter/controller state encoding.
// Ports: none (package only).
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd2,
        WRITE_WAITING  = 3'd3,
        READ_RELAYING  = 3'd4,
        WRITE_RELAYING = 3'd5
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first set bit of req at or after ptr, wrapping.
// Ports: req (request vector), ptr (start index) -> found, idx (winner).
module rr_picker
    import mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int j;

    // Walk from the farthest offset back to ptr so the nearest
    // requester is the last (and therefore winning) assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CONSUMERS clients.
// Ports: clk, reset (async, active-low), per-consumer read/write
// valid/address/data in, ready/data out (flattened vectors), single
// memory read/write channel, busy and grant_id status.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,
    output logic                                 busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id
);

    localparam int N  = NUM_CONSUMERS;
    localparam int IW = $clog2(NUM_CONSUMERS);
    localparam bit WE = (WRITE_ENABLE != 0);

    state_e               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic                 mrv_q, mrv_d;
    logic [ADDR_BITS-1:0] mra_q, mra_d;
    logic                 mwv_q, mwv_d;
    logic [ADDR_BITS-1:0] mwa_q, mwa_d;
    logic [DATA_BITS-1:0] mwd_q, mwd_d;
    logic [N-1:0]         rrdy_q, rrdy_d;
    logic [N-1:0]         wrdy_q, wrdy_d;
    logic [N*DATA_BITS-1:0] rdata_q, rdata_d;

    logic [N-1:0]  req;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] pick_next;

    // Writes are invisible to the scan on a read-only port.
    assign req = consumer_read_valid
               | (WE ? consumer_write_valid : '0);

    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_next = (pick_idx == IW'(N - 1))
                     ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        mrv_d   = mrv_q;
        mra_d   = mra_q;
        mwv_d   = mwv_q;
        mwa_d   = mwa_q;
        mwd_d   = mwd_q;
        rrdy_d  = rrdy_q;
        wrdy_d  = wrdy_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    rr_d    = pick_next;
                    // A consumer asking for both gets its read first.
                    if (consumer_read_valid[pick_idx]) begin
                        mrv_d   = 1'b1;
                        mra_d   = consumer_read_address
                                  [pick_idx*ADDR_BITS +: ADDR_BITS];
                        state_d = READ_WAITING;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = consumer_write_address
                                  [pick_idx*ADDR_BITS +: ADDR_BITS];
                        mwd_d   = consumer_write_data
                                  [pick_idx*DATA_BITS +: DATA_BITS];
                        state_d = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mrv_d = 1'b1 ^ 1'b1;
                    rdata_d[grant_q*DATA_BITS +: DATA_BITS] =
                        mem_read_data;
                    rrdy_d[grant_q] = 1'b1;
                    state_d = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mwv_d = 1'b0;
                    wrdy_d[grant_q] = 1'b1;
                    state_d = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[grant_q]) begin
                    rrdy_d[grant_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_q]) begin
                    wrdy_d[grant_q] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            mrv_q   <= 1'b0;
            mra_q   <= '0;
            mwv_q   <= 1'b0;
            mwa_q   <= '0;
            mwd_q   <= '0;
            rrdy_q  <= '0;
            wrdy_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            mrv_q   <= mrv_d;
            mra_q   <= mra_d;
            mwv_q   <= mwv_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            rrdy_q  <= rrdy_d;
            wrdy_q  <= wrdy_d;
            rdata_q <= rdata_d;
        end
    end

    assign consumer_read_ready  = rrdy_q;
    assign consumer_read_data   = rdata_q;
    assign consumer_write_ready = WE ? wrdy_q : '0;
    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = WE & mwv_q;
    assign mem_write_address    = WE ? mwa_q : '0;
    assign mem_write_data       = WE ? mwd_q : '0;
    assign busy                 = (state_q != IDLE);
    assign grant_id             = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a read/write instance and a read-only
// instance, each scenario in its own task with inline checks.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]  rv, wv, rdy, wrdy;
    logic [31:0] ra, wa;
    logic [63:0] wd, rdata;
    logic        mrv, mwv, mrr, mwr, busy;
    logic [7:0]  mra, mwa;
    logic [15:0] mrd, mwd;
    logic [1:0]  gid;

    logic [3:0]  ro_rv, ro_wv, ro_rdy, ro_wrdy;
    logic [31:0] ro_ra, ro_wa;
    logic [63:0] ro_wd, ro_rdata;
    logic        ro_mrv, ro_mwv, ro_mrr, ro_mwr, ro_busy;
    logic [7:0]  ro_mra, ro_mwa;
    logic [15:0] ro_mrd, ro_mwd;
    logic [1:0]  ro_gid;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(16),
        .NUM_CONSUMERS(4), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv),
        .consumer_read_address(ra),
        .consumer_read_ready(rdy),
        .consumer_read_data(rdata),
        .consumer_write_valid(wv),
        .consumer_write_address(wa),
        .consumer_write_data(wd),
        .consumer_write_ready(wrdy),
        .mem_read_valid(mrv),
        .mem_read_address(mra),
        .mem_read_ready(mrr),
        .mem_read_data(mrd),
        .mem_write_valid(mwv),
        .mem_write_address(mwa),
        .mem_write_data(mwd),
        .mem_write_ready(mwr),
        .busy(busy),
        .grant_id(gid)
    );

    mem_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(16),
        .NUM_CONSUMERS(4), .WRITE_ENABLE(0)
    ) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(ro_rv),
        .consumer_read_address(ro_ra),
        .consumer_read_ready(ro_rdy),
        .consumer_read_data(ro_rdata),
        .consumer_write_valid(ro_wv),
        .consumer_write_address(ro_wa),
        .consumer_write_data(ro_wd),
        .consumer_write_ready(ro_wrdy),
        .mem_read_valid(ro_mrv),
        .mem_read_address(ro_mra),
        .mem_read_ready(ro_mrr),
        .mem_read_data(ro_mrd),
        .mem_write_valid(ro_mwv),
        .mem_write_address(ro_mwa),
        .mem_write_data(ro_mwd),
        .mem_write_ready(ro_mwr),
        .busy(ro_busy),
        .grant_id(ro_gid)
    );

    // Bounded wait for a memory request: 0 = rw read, 1 = rw write,
    // 2 = read-only instance read.
    task automatic wait_valid(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel == 0 && mrv) || (sel == 1 && mwv) ||
                (sel == 2 && ro_mrv)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({mrv, mwv, busy} !== 3'b000) begin
            errs++;
            $display("FAIL reset_valid: got %b want 000",
                     {mrv, mwv, busy});
        end
        vecs++;
        if ({rdy, wrdy, gid} !== 10'h0) begin
            errs++;
            $display("FAIL reset_ready: got %h want 0",
                     {rdy, wrdy, gid});
        end
        vecs++;
        if (rdata !== 64'h0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0", rdata);
        end
        vecs++;
        if ({ro_mrv, ro_busy, ro_rdy} !== 6'h0) begin
            errs++;
            $display("FAIL reset_ro: got %h want 0",
                     {ro_mrv, ro_busy, ro_rdy});
        end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        bit ok;
        @(negedge clk);
        rv[2] = 1'b1;
        ra[23:16] = 8'h1A;
        wait_valid(0, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL single_grant: timeout got 0 want 1");
        end
        vecs++;
        if ({gid, mra, busy} !== {2'd2, 8'h1A, 1'b1}) begin
            errs++;
            $display("FAIL single_req: got %h want %h",
                     {gid, mra, busy}, {2'd2, 8'h1A, 1'b1});
        end
        repeat (3) @(negedge clk);
        vecs++;
        if ({mrv, rdy} !== 5'b1_0000) begin
            errs++;
            $display("FAIL single_wait: got %b want 10000",
                     {mrv, rdy});
        end
        mrr = 1'b1;
        mrd = 16'hBEEF;
        @(negedge clk);
        mrr = 1'b0;
        vecs++;
        if ({mrv, rdy, rdata[47:32]} !== {1'b0, 4'b0100, 16'hBEEF}) begin
            errs++;
            $display("FAIL single_resp: got %h want %h",
                     {mrv, rdy, rdata[47:32]},
                     {1'b0, 4'b0100, 16'hBEEF});
        end
        rv[2] = 1'b0;
        @(negedge clk);
        vecs++;
        if ({rdy, busy} !== 5'b0) begin
            errs++;
            $display("FAIL single_release: got %b want 0",
                     {rdy, busy});
        end
        // Pointer now at 3: consumer 3 must beat consumer 1.
        rv[1] = 1'b1; ra[15:8]  = 8'h11;
        rv[3] = 1'b1; ra[31:24] = 8'h33;
        wait_valid(0, ok);
        vecs++;
        if (!ok || {gid, mra} !== {2'd3, 8'h33}) begin
            errs++;
            $display("FAIL rr_after_2: got %h want %h",
                     {gid, mra}, {2'd3, 8'h33});
        end
        mrr = 1'b1; mrd = 16'h3333;
        @(negedge clk);
        mrr = 1'b0; rv[3] = 1'b0;
        @(negedge clk);
        wait_valid(0, ok);
        vecs++;
        if (!ok || {gid, mra} !== {2'd1, 8'h11}) begin
            errs++;
            $display("FAIL rr_then_1: got %h want %h",
                     {gid, mra}, {2'd1, 8'h11});
        end
        mrr = 1'b1; mrd = 16'h1111;
        @(negedge clk);
        mrr = 1'b0; rv[1] = 1'b0;
        @(negedge clk);
        vecs++;
        if (rdata !== 64'h3333_BEEF_1111_0000) begin
            errs++;
            $display("FAIL rdata_hold: got %h want %h",
                     rdata, 64'h3333_BEEF_1111_0000);
        end
    endtask

    task automatic test_all_four();
        bit ok;
        logic [1:0] e;
        pulse_reset();
        rv = 4'hF;
        ra = 32'h13_12_11_10;
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            wait_valid(0, ok);
            vecs++;
            if (!ok || gid !== e || mra !== 8'h10 + 8'(e)) begin
                errs++;
                $display("FAIL order_%0d: got %0d/%h want %0d/%h",
                         i, gid, mra, e, 8'h10 + 8'(e));
            end
            mrr = 1'b1;
            mrd = 16'h1000 + 16'(i);
            @(negedge clk);
            mrr = 1'b0;
            vecs++;
            if (rdy !== 4'(1 << e)) begin
                errs++;
                $display("FAIL order_rdy_%0d: got %b want %b",
                         i, rdy, 4'(1 << e));
            end
            rv[e] = 1'b0;
            @(negedge clk);
            rv[e] = 1'b1;
        end
        rv = '0;
        vecs++;
        if (rdata !== 64'h1003_1002_1001_1004) begin
            errs++;
            $display("FAIL order_data: got %h want %h",
                     rdata, 64'h1003_1002_1001_1004);
        end
    endtask

    task automatic test_rw_same();
        bit ok;
        pulse_reset();
        rv[1] = 1'b1; ra[15:8] = 8'h41;
        wv[1] = 1'b1; wa[15:8] = 8'h40;
        wd[31:16] = 16'h0055;
        wait_valid(0, ok);
        vecs++;
        if (!ok || {gid, mra, mwv} !== {2'd1, 8'h41, 1'b0}) begin
            errs++;
            $display("FAIL rw_read_first: got %h want %h",
                     {gid, mra, mwv}, {2'd1, 8'h41, 1'b0});
        end
        mrr = 1'b1; mrd = 16'hAAAA;
        @(negedge clk);
        mrr = 1'b0;
        vecs++;
        if ({rdy, wrdy} !== 8'b0010_0000) begin
            errs++;
            $display("FAIL rw_read_rdy: got %b want 00100000",
                     {rdy, wrdy});
        end
        rv[1] = 1'b0;
        rv[3] = 1'b1; ra[31:24] = 8'h30;
        @(negedge clk);
        wait_valid(0, ok);
        vecs++;
        if (!ok || gid !== 2'd3) begin
            errs++;
            $display("FAIL rw_mid_grant: got %0d want 3", gid);
        end
        mrr = 1'b1;
        @(negedge clk);
        mrr = 1'b0; rv[3] = 1'b0;
        @(negedge clk);
        wait_valid(1, ok);
        vecs++;
        if (!ok || {gid, mwa, mwd, mrv} !==
            {2'd1, 8'h40, 16'h0055, 1'b0}) begin
            errs++;
            $display("FAIL rw_write: got %h want %h",
                     {gid, mwa, mwd, mrv},
                     {2'd1, 8'h40, 16'h0055, 1'b0});
        end
        mwr = 1'b1;
        @(negedge clk);
        mwr = 1'b0;
        vecs++;
        if ({wrdy, mwv} !== 5'b0010_0) begin
            errs++;
            $display("FAIL rw_write_rdy: got %b want 00100",
                     {wrdy, mwv});
        end
        wv[1] = 1'b0;
        @(negedge clk);
        vecs++;
        if ({wrdy, busy} !== 5'b0) begin
            errs++;
            $display("FAIL rw_write_rel: got %b want 0",
                     {wrdy, busy});
        end
    endtask

    task automatic test_hold_valid();
        bit ok;
        pulse_reset();
        rv[0] = 1'b1; ra[7:0]  = 8'h05;
        rv[1] = 1'b1; ra[15:8] = 8'h06;
        wait_valid(0, ok);
        vecs++;
        if (!ok || gid !== 2'd0) begin
            errs++;
            $display("FAIL hold_grant: got %0d want 0", gid);
        end
        mrr = 1'b1; mrd = 16'h0A0A;
        @(negedge clk);
        mrr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if ({rdy, busy, mrv} !== 6'b0001_10) begin
                errs++;
                $display("FAIL hold_cyc%0d: got %b want 000110",
                         k, {rdy, busy, mrv});
            end
            @(negedge clk);
        end
        rv[0] = 1'b0;
        @(negedge clk);
        vecs++;
        if ({rdy, busy, mrv} !== 6'b0) begin
            errs++;
            $display("FAIL hold_idle: got %b want 0",
                     {rdy, busy, mrv});
        end
        @(negedge clk);
        vecs++;
        if ({mrv, gid, mra} !== {1'b1, 2'd1, 8'h06}) begin
            errs++;
            $display("FAIL hold_next: got %h want %h",
                     {mrv, gid, mra}, {1'b1, 2'd1, 8'h06});
        end
        mrr = 1'b1;
        @(negedge clk);
        mrr = 1'b0; rv[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_only();
        bit ok;
        ro_wv[0] = 1'b1;
        ro_wa[7:0] = 8'h20;
        ro_wd[15:0] = 16'h1234;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            vecs++;
            if ({ro_mwv, ro_wrdy, ro_busy} !== 6'b0) begin
                errs++;
                $display("FAIL ro_write_%0d: got %b want 0",
                         k, {ro_mwv, ro_wrdy, ro_busy});
            end
        end
        ro_rv[3] = 1'b1;
        ro_ra[31:24] = 8'h3C;
        wait_valid(2, ok);
        vecs++;
        if (!ok || {ro_gid, ro_mra, ro_mwv} !==
            {2'd3, 8'h3C, 1'b0}) begin
            errs++;
            $display("FAIL ro_read: got %h want %h",
                     {ro_gid, ro_mra, ro_mwv}, {2'd3, 8'h3C, 1'b0});
        end
        ro_mrr = 1'b1; ro_mrd = 16'h5A5A;
        @(negedge clk);
        ro_mrr = 1'b0;
        vecs++;
        if ({ro_rdy, ro_wrdy, ro_rdata[63:48]} !==
            {4'b1000, 4'b0000, 16'h5A5A}) begin
            errs++;
            $display("FAIL ro_resp: got %h want %h",
                     {ro_rdy, ro_wrdy, ro_rdata[63:48]},
                     {4'b1000, 4'b0000, 16'h5A5A});
        end
        ro_rv = '0;
        ro_wv = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bit ok;
        pulse_reset();
        rv[0] = 1'b1; ra[7:0] = 8'h77;
        wait_valid(0, ok);
        mrr = 1'b1; mrd = 16'h7777;
        @(negedge clk);
        mrr = 1'b0; rv[0] = 1'b0;
        @(negedge clk);
        rv[2] = 1'b1; ra[23:16] = 8'h22;
        wait_valid(0, ok);
        vecs++;
        if (!ok || gid !== 2'd2) begin
            errs++;
            $display("FAIL mid_pre: got %0d want 2", gid);
        end
        #2;
        reset = 1'b0;
        #1;
        vecs++;
        if ({mrv, busy, gid, rdy} !== 8'h0) begin
            errs++;
            $display("FAIL mid_async: got %h want 0",
                     {mrv, busy, gid, rdy});
        end
        vecs++;
        if (rdata !== 64'h0) begin
            errs++;
            $display("FAIL mid_data: got %h want 0", rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        rv = 4'b1101;
        ra = 32'h33_22_11_00;
        wait_valid(0, ok);
        vecs++;
        if (!ok || {gid, mra} !== {2'd0, 8'h00}) begin
            errs++;
            $display("FAIL mid_restart: got %h want %h",
                     {gid, mra}, {2'd0, 8'h00});
        end
        pulse_reset();
    endtask

    initial begin
        reset = 1'b0;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        ro_rv = '0; ro_wv = '0; ro_ra = '0; ro_wa = '0;
        ro_wd = '0; ro_mrr = 1'b0; ro_mwr = 1'b0; ro_mrd = '0;
        test_reset();
        test_single_read();
        test_all_four();
        test_rw_same();
        test_hold_valid();
        test_read_only();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
